// File: rtl/texture_pkg.sv
// Shared types and width helpers for the texture RAM block.
package texture_pkg;

   localparam int unsigned NumColours = 3;

   typedef enum logic [1:0] {StIdle, StLoad, StDone} ld_state_e;

   function automatic int unsigned pix_w(input int unsigned channel_bits);
      return NumColours * channel_bits;
   endfunction

   function automatic int unsigned addr_w(input int unsigned tex_bits, input int unsigned tw);
      return tw + 2 * tex_bits;
   endfunction

endpackage

// File: rtl/texture_ram_mem.sv
// Simple dual-port texel store: one synchronous write port, one registered read port.
module texture_ram_mem #(
   parameter int unsigned DataW = 6,
   parameter int unsigned AddrW = 14
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [AddrW-1:0] waddr_i,
   input  logic [DataW-1:0] wdata_i,
   input  logic             re_i,
   input  logic [AddrW-1:0] raddr_i,
   output logic [DataW-1:0] rdata_o
);

   logic [DataW-1:0] mem_q [(1 << AddrW)];
   logic [DataW-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/texture_ram.sv
// Texture store with a streaming loader FSM and a 1-cycle read port that blanks
// reads of the texture currently being loaded.
module texture_ram
   import texture_pkg::*;
#(
   parameter int unsigned CHANNEL_BITS = 2,
   parameter int unsigned TEX_BITS     = 6,
   parameter int unsigned TEX_COUNT    = 4,
   localparam int unsigned TW          = $clog2(TEX_COUNT),
   localparam int unsigned PW          = pix_w(CHANNEL_BITS)
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                rd_en,
   input  logic [TW-1:0]       rd_tex,
   input  logic [TEX_BITS-1:0] rd_col,
   input  logic [TEX_BITS-1:0] rd_row,
   output logic [PW-1:0]       rd_val,
   output logic                rd_valid,
   input  logic                ld_start,
   input  logic [TW-1:0]       ld_tex,
   input  logic [PW-1:0]       ld_data,
   input  logic                ld_valid,
   output logic                ld_ready,
   output logic                ld_busy,
   output logic                ld_done
);

   localparam int unsigned CW = 2 * TEX_BITS;
   localparam int unsigned AW = addr_w(TEX_BITS, TW);

   ld_state_e     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [TW-1:0] tex_q, tex_d;
   logic          ld_ready_q, ld_ready_d;
   logic          ld_busy_q, ld_busy_d;
   logic          ld_done_q, ld_done_d;
   logic          rd_valid_q, rd_valid_d;
   logic          rd_ok_q, rd_ok_d;
   logic          blank_q, blank_d;
   logic          mem_we;
   logic [PW-1:0] mem_rdata;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      tex_d      = tex_q;
      mem_we     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (ld_start) begin
               tex_d   = ld_tex;
               cnt_d   = '0;
               state_d = StLoad;
            end
         end
         StLoad: begin
            if (ld_valid) begin
               mem_we = 1'b1;
               cnt_d  = cnt_q + 1'b1;
               if (&cnt_q) begin
                  state_d = StDone;
               end
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
      ld_ready_d = (state_d == StLoad);
      ld_busy_d  = (state_d == StLoad);
      ld_done_d  = (state_d == StDone);

      // Read side only updates on a request so rd_val holds between reads.
      rd_valid_d = rd_en;
      rd_ok_d    = rd_ok_q;
      blank_d    = blank_q;
      if (rd_en) begin
         rd_ok_d = 1'b1;
         blank_d = ld_busy_q && (rd_tex == tex_q);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         tex_q      <= '0;
         ld_ready_q <= 1'b0;
         ld_busy_q  <= 1'b0;
         ld_done_q  <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_ok_q    <= 1'b0;
         blank_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         tex_q      <= tex_d;
         ld_ready_q <= ld_ready_d;
         ld_busy_q  <= ld_busy_d;
         ld_done_q  <= ld_done_d;
         rd_valid_q <= rd_valid_d;
         rd_ok_q    <= rd_ok_d;
         blank_q    <= blank_d;
      end
   end

   texture_ram_mem #(
      .DataW (PW),
      .AddrW (AW)
   ) u_mem (
      .clk_i   (clk),
      .we_i    (mem_we),
      .waddr_i ({tex_q, cnt_q}),
      .wdata_i (ld_data),
      .re_i    (rd_en),
      .raddr_i ({rd_tex, rd_col, rd_row}),
      .rdata_o (mem_rdata)
   );

   // The RAM has no reset, so mask its output until the first post-reset read.
   assign rd_val   = (rd_ok_q && !blank_q) ? mem_rdata : '0;
   assign rd_valid = rd_valid_q;
   assign ld_ready = ld_ready_q;
   assign ld_busy  = ld_busy_q;
   assign ld_done  = ld_done_q;

endmodule

// File: tb/tb_texture_ram.sv
// Scoreboard bench for texture_ram: default instance plus a small parameter sweep.
module tb_texture_ram;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       rd_en, rd_valid, ld_start, ld_valid, ld_ready, ld_busy, ld_done;
   logic [1:0] rd_tex, ld_tex;
   logic [5:0] rd_col, rd_row, rd_val, ld_data;

   logic       s_rd_en, s_rd_tex, s_ld_start, s_ld_tex, s_ld_valid;
   logic [3:0] s_rd_col, s_rd_row;
   logic [8:0] s_ld_data, s3_rd_val;
   logic [2:0] s1_rd_val;
   logic       s1_rd_valid, s1_ld_ready, s1_ld_busy, s1_ld_done;
   logic       s3_rd_valid, s3_ld_ready, s3_ld_busy, s3_ld_done;

   always #5 clk = ~clk;

   texture_ram u_dut (
      .clk(clk), .reset_n(reset_n), .rd_en(rd_en), .rd_tex(rd_tex), .rd_col(rd_col),
      .rd_row(rd_row), .rd_val(rd_val), .rd_valid(rd_valid), .ld_start(ld_start),
      .ld_tex(ld_tex), .ld_data(ld_data), .ld_valid(ld_valid), .ld_ready(ld_ready),
      .ld_busy(ld_busy), .ld_done(ld_done)
   );

   texture_ram #(.CHANNEL_BITS(1), .TEX_BITS(4), .TEX_COUNT(2)) u_s1 (
      .clk(clk), .reset_n(reset_n), .rd_en(s_rd_en), .rd_tex(s_rd_tex), .rd_col(s_rd_col),
      .rd_row(s_rd_row), .rd_val(s1_rd_val), .rd_valid(s1_rd_valid), .ld_start(s_ld_start),
      .ld_tex(s_ld_tex), .ld_data(s_ld_data[2:0]), .ld_valid(s_ld_valid),
      .ld_ready(s1_ld_ready), .ld_busy(s1_ld_busy), .ld_done(s1_ld_done)
   );

   texture_ram #(.CHANNEL_BITS(3), .TEX_BITS(4), .TEX_COUNT(2)) u_s3 (
      .clk(clk), .reset_n(reset_n), .rd_en(s_rd_en), .rd_tex(s_rd_tex), .rd_col(s_rd_col),
      .rd_row(s_rd_row), .rd_val(s3_rd_val), .rd_valid(s3_rd_valid), .ld_start(s_ld_start),
      .ld_tex(s_ld_tex), .ld_data(s_ld_data), .ld_valid(s_ld_valid),
      .ld_ready(s3_ld_ready), .ld_busy(s3_ld_busy), .ld_done(s3_ld_done)
   );

   typedef struct packed {
      logic [5:0]  val;
      logic        care;
      int unsigned due;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        mon_e;
   int          n_checks = 0;
   int          n_pass = 0;
   int          x_seen = 0;
   int          done_cnt = 0;
   int unsigned cyc = 0;
   logic [5:0]  model [4][4096];
   bit          known [4][4096];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
   endtask

   function automatic logic [5:0] pat(input int t, input int i);
      if (t == 2) return 6'(i % 64);
      return 6'((i * 5 + t * 7) % 64);
   endfunction

   function automatic logic [8:0] spat(input int i);
      return 9'((i * 37 + 11) % 512);
   endfunction

   always @(posedge clk) cyc++;

   // Monitor: pops one expectation per rd_valid and checks value and latency.
   always @(negedge clk) begin
      if ((^{rd_valid, ld_ready, ld_busy, ld_done}) === 1'bx) x_seen++;
      if (ld_done === 1'b1) done_cnt++;
      if (rd_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            check("unexpected_rd_valid", 32'd1, 32'd0);
         end else begin
            mon_e = sb_q.pop_front();
            check("rd_latency", cyc, mon_e.due);
            if (mon_e.care) check("rd_val", {26'd0, rd_val}, {26'd0, mon_e.val});
         end
      end
   end

   task automatic issue_read(input int t, input int idx, input logic care, input logic [5:0] v);
      rd_en  = 1'b1;
      rd_tex = 2'(t);
      rd_col = 6'(idx / 64);
      rd_row = 6'(idx % 64);
      sb_q.push_back('{val: v, care: care, due: cyc + 1});
   endtask

   task automatic read_known(input int t, input int idx);
      issue_read(t, idx, known[t][idx], model[t][idx]);
   endtask

   // Reads alongside a load: every 8th slot targets the loading texture (blanked).
   task automatic ld_read(input int t, input int other, input int k);
      if (k % 8 == 3) issue_read(t, k % 4096, 1'b1, 6'h00);
      else if (other >= 0) read_known(other, (k * 13) % 4096);
      else rd_en = 1'b0;
   endtask

   task automatic do_load(input int t, input bit gap, input int other, input int stray_tex,
                          input int abort_at);
      int d0;
      @(negedge clk);
      ld_start = 1'b1;
      ld_tex   = 2'(t);
      rd_en    = 1'b0;
      d0       = done_cnt;
      for (int i = 0; i < 4096; i++) begin
         if (gap) begin
            @(negedge clk);
            ld_start = 1'b0;
            ld_valid = 1'b0;
            ld_read(t, other, i * 2);
         end
         @(negedge clk);
         ld_start = 1'b0;
         if (i == 0) begin
            check("ld_busy_in_load", {31'd0, ld_busy}, 32'd1);
            check("ld_ready_in_load", {31'd0, ld_ready}, 32'd1);
         end
         if (i == abort_at) begin
            ld_valid = 1'b0;
            rd_en    = 1'b0;
            #1 reset_n = 1'b0;
            #1;
            check("abort_rd_val", {26'd0, rd_val}, 32'd0);
            check("abort_rd_valid", {31'd0, rd_valid}, 32'd0);
            check("abort_ld_ready", {31'd0, ld_ready}, 32'd0);
            check("abort_ld_busy", {31'd0, ld_busy}, 32'd0);
            check("abort_ld_done", {31'd0, ld_done}, 32'd0);
            @(posedge clk);
            @(negedge clk);
            check("abort_no_done", done_cnt - d0, 32'd0);
            reset_n = 1'b1;
            return;
         end
         ld_valid = 1'b1;
         ld_data  = pat(t, i);
         model[t][i] = pat(t, i);
         known[t][i] = 1'b1;
         if (i == 100 && stray_tex >= 0) begin
            ld_start = 1'b1;
            ld_tex   = 2'(stray_tex);
         end
         ld_read(t, other, i * 2 + 1);
      end
      // Keep ld_valid high in DONE and the following IDLE cycle; nothing may be written.
      @(negedge clk);
      ld_valid = 1'b1;
      ld_data  = 6'h2A;
      rd_en    = 1'b0;
      check("ld_done_pulse", {31'd0, ld_done}, 32'd1);
      check("done_ld_busy", {31'd0, ld_busy}, 32'd0);
      check("done_ld_ready", {31'd0, ld_ready}, 32'd0);
      @(negedge clk);
      check("ld_done_one_cycle", {31'd0, ld_done}, 32'd0);
      check("ld_done_count", done_cnt - d0, 32'd1);
      check("idle_ld_ready", {31'd0, ld_ready}, 32'd0);
      @(negedge clk);
      ld_valid = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0;
      {rd_en, ld_start, ld_valid} = '0;
      {rd_tex, ld_tex, rd_col, rd_row, ld_data} = '0;
      {s_rd_en, s_rd_tex, s_ld_start, s_ld_tex, s_ld_valid} = '0;
      {s_rd_col, s_rd_row, s_ld_data} = '0;
      #3;
      check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
      check("rst_rd_val", {26'd0, rd_val}, 32'd0);
      check("rst_ctrl", {29'd0, ld_ready, ld_busy, ld_done}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;

      @(negedge clk);
      issue_read(0, 0, 1'b0, 6'h00);
      @(negedge clk);
      rd_en = 1'b0;

      do_load(2, 1'b1, -1, -1, -1);
      @(negedge clk) issue_read(2, 1 * 64 + 3, 1'b1, 6'h03);
      @(negedge clk) issue_read(2, 0, 1'b1, 6'h00);
      @(negedge clk) issue_read(2, 4095, 1'b1, 6'h3F);
      @(negedge clk) rd_en = 1'b0;
      @(negedge clk);
      check("hold_rd_valid", {31'd0, rd_valid}, 32'd0);
      check("hold_rd_val", {26'd0, rd_val}, 32'h3F);

      do_load(1, 1'b0, 2, 0, -1);
      @(negedge clk) issue_read(1, 0, 1'b1, 6'h07);
      @(negedge clk) read_known(1, 500);
      @(negedge clk) issue_read(2, 67, 1'b1, 6'h03);
      @(negedge clk) rd_en = 1'b0;

      do_load(3, 1'b0, 2, -1, 1000);
      @(negedge clk) read_known(3, 5);
      @(negedge clk) read_known(2, 1000);
      @(negedge clk) rd_en = 1'b0;
      do_load(3, 1'b0, 2, -1, -1);
      @(negedge clk) read_known(3, 4095);
      @(negedge clk) read_known(1, 4000);
      @(negedge clk) rd_en = 1'b0;

      @(negedge clk);
      s_ld_start = 1'b1;
      s_ld_tex   = 1'b1;
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         s_ld_start = 1'b0;
         s_ld_valid = 1'b1;
         s_ld_data  = spat(i);
      end
      @(negedge clk);
      s_ld_valid = 1'b0;
      check("sweep_s1_done", {31'd0, s1_ld_done}, 32'd1);
      check("sweep_s3_done", {31'd0, s3_ld_done}, 32'd1);
      for (int k = 0; k < 4; k++) begin
         int idx;
         logic [8:0] ev;
         idx = (k == 0) ? 0 : (k == 1) ? 17 : (k == 2) ? 200 : 255;
         ev  = spat(idx);
         s_rd_en  = 1'b1;
         s_rd_tex = 1'b1;
         s_rd_col = 4'(idx / 16);
         s_rd_row = 4'(idx % 16);
         @(negedge clk);
         s_rd_en = 1'b0;
         check("sweep_s3_val", {23'd0, s3_rd_val}, {23'd0, ev});
         check("sweep_s1_val", {29'd0, s1_rd_val}, {29'd0, ev[2:0]});
         check("sweep_valid", {30'd0, s1_rd_valid, s3_rd_valid}, 32'd3);
      end

      for (int k = 0; k < 10 && sb_q.size() != 0; k++) @(negedge clk);
      check("sb_drained", sb_q.size(), 32'd0);
      check("no_x_ctrl", x_seen, 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
